// File: rtl/fir_ctrl_pkg.sv
// Shared constants, types and state encoding for the FIR sequencer.
// FIR_FLUSH_EN enables the FLUSH state (10 zero-sample enables after iStop).
package fir_ctrl_pkg;

    localparam int NUM_TAPS   = 10;
    localparam int COEFF_W    = 16;
    localparam int IN_W       = 3;
    localparam int FILL_DEPTH = 11;
    localparam int FILL_W     = 4;
    localparam int ADDR_W     = 4;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic signed [IN_W-1:0]    sample_t;
    typedef logic [ADDR_W-1:0]         addr_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Coefficient write bus between the sequencer and the coefficient bank.
interface fir_seq_ctrl_if;
    import fir_ctrl_pkg::*;

    logic   we;
    addr_t  addr;
    coeff_t data;

    modport master (output we, output addr, output data);
    modport slave  (input we, input addr, input data);

endinterface

// File: rtl/fir_coeff_bank.sv
// Ten registered tap coefficients with a single write port.
module fir_coeff_bank
    import fir_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fir_seq_ctrl_if.slave  wr,
    output coeff_t         coeff_o [NUM_TAPS]
);

    coeff_t coeff_q [NUM_TAPS];
    coeff_t coeff_d [NUM_TAPS];

    // Addresses past the last tap match no entry and are dropped.
    always_comb begin
        coeff_d = coeff_q;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (wr.we && wr.addr == ADDR_W'(i)) begin
                coeff_d[i] = wr.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coeff_q[i] <= '0;
            end
        end else begin
            coeff_q <= coeff_d;
        end
    end

    assign coeff_o = coeff_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: coefficient load, datapath clear, sample streaming, result qualify.
// Define FIR_FLUSH_EN to add the FLUSH state that pushes 10 zero samples after iStop.
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
(
    input  logic         iClk_12M,
    input  logic         iRsn,
    input  logic         iCoeffWe,
    input  logic [3:0]   iCoeffAddr,
    input  coeff_t       iCoeffData,
    input  logic         iStart,
    input  logic         iStop,
    input  logic         iInValid,
    input  sample_t      iInData,
    output logic         oInReady,
    output coeff_t       oCoeff1,
    output coeff_t       oCoeff2,
    output coeff_t       oCoeff3,
    output coeff_t       oCoeff4,
    output coeff_t       oCoeff5,
    output coeff_t       oCoeff6,
    output coeff_t       oCoeff7,
    output coeff_t       oCoeff8,
    output coeff_t       oCoeff9,
    output coeff_t       oCoeff10,
    output sample_t      oFirIn,
    output logic         oEnAcc,
    output logic         oFirRsn,
    input  coeff_t       iMac,
    output logic         oOutValid,
    output coeff_t       oOutData,
    output logic         oBusy,
    output logic [1:0]   oState
);

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                en_acc_q, en_acc_d;
    logic                fir_rsn_q, fir_rsn_d;
    logic                out_vld_q, out_vld_d;
    sample_t             fir_in_q, fir_in_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
`ifdef FIR_FLUSH_EN
    logic [3:0]          flush_cnt_q, flush_cnt_d;
`endif

    logic   in_acc;
    coeff_t coeff [NUM_TAPS];

    fir_seq_ctrl_if cw ();

    assign cw.we   = iCoeffWe && (state_q == S_IDLE);
    assign cw.addr = iCoeffAddr;
    assign cw.data = iCoeffData;

    fir_coeff_bank u_bank (
        .clk     (iClk_12M),
        .rst_n   (iRsn),
        .wr      (cw),
        .coeff_o (coeff)
    );

    // A stop request closes the ready window in the same cycle.
    assign oInReady = ready_q & ~iStop;
    assign in_acc   = iInValid & oInReady;

    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        en_acc_d  = 1'b1;
        fir_rsn_d = 1'b1;
        fir_in_d  = fir_in_q;
        fill_d    = fill_q;
        out_vld_d = 1'b0;
`ifdef FIR_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif
        if (!en_acc_q && fill_q != FILL_W'(FILL_DEPTH)) begin
            fill_d = fill_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d   = S_CLEAR;
                    fir_rsn_d = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
                ready_d = 1'b1;
                fill_d  = '0;
            end
            S_RUN: begin
                if (iStop) begin
`ifdef FIR_FLUSH_EN
                    state_d     = S_FLUSH;
                    en_acc_d    = 1'b0;
                    fir_in_d    = '0;
                    flush_cnt_d = '0;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    ready_d = 1'b1;
                    if (in_acc) begin
                        fir_in_d = iInData;
                        en_acc_d = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
`ifdef FIR_FLUSH_EN
                if (flush_cnt_q == 4'(NUM_TAPS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    en_acc_d    = 1'b0;
                    fir_in_d    = '0;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        // Result lands one cycle after the enable that completes the fill.
        out_vld_d = !en_acc_q && (fill_d == FILL_W'(FILL_DEPTH));
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            en_acc_q  <= 1'b1;
            fir_rsn_q <= 1'b1;
            out_vld_q <= 1'b0;
            fir_in_q  <= '0;
            fill_q    <= '0;
`ifdef FIR_FLUSH_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            en_acc_q  <= en_acc_d;
            fir_rsn_q <= fir_rsn_d;
            out_vld_q <= out_vld_d;
            fir_in_q  <= fir_in_d;
            fill_q    <= fill_d;
`ifdef FIR_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    assign oFirIn    = fir_in_q;
    assign oEnAcc    = en_acc_q;
    assign oFirRsn   = fir_rsn_q;
    assign oOutValid = out_vld_q;
    assign oOutData  = out_vld_q ? iMac : '0;
    assign oBusy     = (state_q != S_IDLE);
    assign oState    = state_q;

    assign oCoeff1  = coeff[0];
    assign oCoeff2  = coeff[1];
    assign oCoeff3  = coeff[2];
    assign oCoeff4  = coeff[3];
    assign oCoeff5  = coeff[4];
    assign oCoeff6  = coeff[5];
    assign oCoeff7  = coeff[6];
    assign oCoeff8  = coeff[7];
    assign oCoeff9  = coeff[8];
    assign oCoeff10 = coeff[9];

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl with a 10-tap registered MAC datapath model attached.
// Builds with or without FIR_FLUSH_EN.
module tb_fir_seq_ctrl;

    logic        iClk_12M = 1'b0;
    logic        iRsn;
    logic        iStart, iStop, iInValid;
    logic [2:0]  iInData;
    logic        oInReady, oEnAcc, oFirRsn, oOutValid, oBusy;
    logic [2:0]  oFirIn;
    logic [1:0]  oState;
    logic [15:0] oOutData, mac_q;
    logic [15:0] oc [10];

    fir_seq_ctrl_if cif ();

    int n_chk  = 0;
    int n_fail = 0;

    always #5 iClk_12M = ~iClk_12M;

    fir_seq_ctrl dut (
        .iClk_12M   (iClk_12M),
        .iRsn       (iRsn),
        .iCoeffWe   (cif.we),
        .iCoeffAddr (cif.addr),
        .iCoeffData (cif.data),
        .iStart     (iStart),
        .iStop      (iStop),
        .iInValid   (iInValid),
        .iInData    (iInData),
        .oInReady   (oInReady),
        .oCoeff1    (oc[0]),
        .oCoeff2    (oc[1]),
        .oCoeff3    (oc[2]),
        .oCoeff4    (oc[3]),
        .oCoeff5    (oc[4]),
        .oCoeff6    (oc[5]),
        .oCoeff7    (oc[6]),
        .oCoeff8    (oc[7]),
        .oCoeff9    (oc[8]),
        .oCoeff10   (oc[9]),
        .oFirIn     (oFirIn),
        .oEnAcc     (oEnAcc),
        .oFirRsn    (oFirRsn),
        .iMac       (mac_q),
        .oOutValid  (oOutValid),
        .oOutData   (oOutData),
        .oBusy      (oBusy),
        .oState     (oState)
    );

    // Datapath: result register lags the tap line by one enable.
    logic signed [2:0] x [10];
    always @(posedge iClk_12M) begin : dp
        int s;
        if (!iRsn || !oFirRsn) begin
            mac_q <= '0;
            for (int i = 0; i < 10; i++) x[i] <= '0;
        end else if (!oEnAcc) begin
            s = 0;
            for (int i = 0; i < 10; i++)
                s += int'($signed(oc[i])) * int'(x[i]);
            mac_q <= 16'(s);
            x[0] <= oFirIn;
            for (int i = 1; i < 10; i++) x[i] <= x[i-1];
        end
    end

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        start;
        logic        vld;
        logic [2:0]  din;
        logic [1:0]  e_state;
        logic        e_ready;
        logic        e_en;
        logic        e_rsn;
        logic [2:0]  e_fin;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [3:0] a, logic [15:0] d,
                                logic st, logic v, logic [2:0] di,
                                logic [1:0] es, logic er, logic ee,
                                logic ers, logic [2:0] ef);
        vec_t r;
        r.we = we; r.addr = a; r.data = d; r.start = st;
        r.vld = v; r.din = di; r.e_state = es; r.e_ready = er;
        r.e_en = ee; r.e_rsn = ers; r.e_fin = ef;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk_12M);
        #1;
    endtask

    task automatic idle_inputs;
        cif.we = 1'b0; cif.addr = '0; cif.data = '0;
        iStart = 1'b0; iStop = 1'b0; iInValid = 1'b0; iInData = '0;
    endtask

    task automatic start_run;
        iStart = 1'b1;
        tick;
        chk("start_clear_state", 32'(oState), 32'd1);
        chk("start_clear_rsn", 32'(oFirRsn), 32'd0);
        iStart = 1'b0;
        tick;
        chk("start_run_state", 32'(oState), 32'd2);
        chk("start_run_rsn", 32'(oFirRsn), 32'd1);
        chk("start_run_ready", 32'(oInReady), 32'd1);
    endtask

    task automatic do_stop(input logic [2:0] fin_hold);
        iStop = 1'b1; iInValid = 1'b1; iInData = 3'd2;
        #1;
        chk("stop_ready_low", 32'(oInReady), 32'd0);
        tick;
        iStop = 1'b0; iInValid = 1'b0;
`ifdef FIR_FLUSH_EN
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("flush%0d_state", k), 32'(oState), 32'd3);
            chk($sformatf("flush%0d_en", k), 32'(oEnAcc), 32'd0);
            chk($sformatf("flush%0d_fin", k), 32'(oFirIn), 32'd0);
            tick;
        end
`else
        chk("stop_fin_hold", 32'(oFirIn), 32'(fin_hold));
`endif
        chk("stop_idle_state", 32'(oState), 32'd0);
        chk("stop_idle_en", 32'(oEnAcc), 32'd1);
        chk("stop_idle_busy", 32'(oBusy), 32'd0);
    endtask

    task automatic stream(input logic [2:0] s, input logic [15:0] exp);
        start_run;
        iInValid = 1'b1; iInData = s;
        for (int k = 1; k <= 11; k++) begin
            tick;
            chk($sformatf("strm%0d_en", k), 32'(oEnAcc), 32'd0);
            chk($sformatf("strm%0d_ovld", k), 32'(oOutValid), 32'd0);
        end
        iInValid = 1'b0;
        tick;
        chk("strm_res_en", 32'(oEnAcc), 32'd1);
        chk("strm_res_vld", 32'(oOutValid), 32'd1);
        chk("strm_res_data", 32'(oOutData), 32'(exp));
        tick;
        chk("strm_after_vld", 32'(oOutValid), 32'd0);
        do_stop(s);
    endtask

    initial begin
        idle_inputs;
        iRsn = 1'b0;
        tick;
        tick;
        chk("rst_state", 32'(oState), 32'd0);
        chk("rst_ready", 32'(oInReady), 32'd0);
        chk("rst_en", 32'(oEnAcc), 32'd1);
        chk("rst_rsn", 32'(oFirRsn), 32'd1);
        chk("rst_ovld", 32'(oOutValid), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_coeff1", 32'(oc[0]), 32'd0);
        iRsn = 1'b1;
        tick;

        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 4'(i), 16'(i + 1), 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 12, 16'h1234, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 16'h5555, 0, 1, 1, 2, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 2, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 2, 1, 0, 1, 7));

        foreach (tbl[i]) begin
            cif.we = tbl[i].we; cif.addr = tbl[i].addr;
            cif.data = tbl[i].data; iStart = tbl[i].start;
            iInValid = tbl[i].vld; iInData = tbl[i].din;
            tick;
            chk($sformatf("vec%0d_state", i), 32'(oState), 32'(tbl[i].e_state));
            chk($sformatf("vec%0d_ready", i), 32'(oInReady), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d_en", i), 32'(oEnAcc), 32'(tbl[i].e_en));
            chk($sformatf("vec%0d_rsn", i), 32'(oFirRsn), 32'(tbl[i].e_rsn));
            chk($sformatf("vec%0d_fin", i), 32'(oFirIn), 32'(tbl[i].e_fin));
            chk($sformatf("vec%0d_busy", i), 32'(oBusy),
                32'(tbl[i].e_state != 2'd0));
        end
        idle_inputs;
        do_stop(3'd7);

        for (int i = 0; i < 10; i++)
            chk($sformatf("coeff%0d", i + 1), 32'(oc[i]), 32'(i + 1));

        stream(3'd1, 16'd55);
        stream(3'b111, 16'hFFC9);

        start_run;
        iInData = 3'd1;
        for (int k = 0; k < 8; k++) begin
            iInValid = (k % 2 == 0);
            tick;
            chk($sformatf("tog%0d_en", k), 32'(oEnAcc), 32'(k % 2 != 0));
        end
        iInValid = 1'b0;
        tick;
        do_stop(3'd1);

        iStart = 1'b1;
        cif.we = 1'b1; cif.addr = 4'd3; cif.data = 16'h7FFF;
        tick;
        idle_inputs;
        chk("sw_coeff4", 32'(oc[3]), 32'h7FFF);
        chk("sw_coeff3", 32'(oc[2]), 32'd3);
        chk("sw_state_clear", 32'(oState), 32'd1);
        chk("sw_rsn_low", 32'(oFirRsn), 32'd0);
        tick;
        chk("sw_state_run", 32'(oState), 32'd2);
        chk("sw_rsn_high", 32'(oFirRsn), 32'd1);
        tick;
        chk("sw_state_run2", 32'(oState), 32'd2);

        iInValid = 1'b1; iInData = 3'd3;
        tick;
        chk("mr_en", 32'(oEnAcc), 32'd0);
        chk("mr_fin", 32'(oFirIn), 32'd3);
        #2;
        iRsn = 1'b0;
        #1;
        chk("mr_state", 32'(oState), 32'd0);
        chk("mr_coeff1", 32'(oc[0]), 32'd0);
        chk("mr_coeff4", 32'(oc[3]), 32'd0);
        chk("mr_fin0", 32'(oFirIn), 32'd0);
        chk("mr_en1", 32'(oEnAcc), 32'd1);
        chk("mr_rsn1", 32'(oFirRsn), 32'd1);
        chk("mr_ready0", 32'(oInReady), 32'd0);
        chk("mr_ovld0", 32'(oOutValid), 32'd0);
        chk("mr_odata0", 32'(oOutData), 32'd0);
        chk("mr_busy0", 32'(oBusy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
